// File: rtl/sata_dev_oob_ctrl.sv
// sata_dev_oob_ctrl: device-side SATA OOB responder. It answers the host's
// COMRESET with COMINIT, waits for the host COMWAKE, answers with COMWAKE,
// then sends ALIGN until the receiver locks and reports PHY ready.
// Optional statistics counters are built when SATA_DEV_OOB_STATS_EN is defined.
module sata_dev_oob_ctrl #(
  parameter int COMINIT_DELAY_CYC     = 60,
  parameter int WAKE_TIMEOUT_CYC      = 600000,
  parameter int ALIGN_TIMEOUT_CYC     = 52800,
  parameter int COMFINISH_TIMEOUT_CYC = 4096,
  parameter int MAX_RETRY             = 3
) (
  input  logic        rstn,
  input  logic        cpll_refclk,
  input  logic        i_rx_comreset_det,
  input  logic        i_rx_comwake_det,
  input  logic        i_tx_comfinish,
  input  logic        i_rx_aligned,
  output logic        o_tx_cominit,
  output logic        o_tx_comwake,
  output logic        o_tx_elecidle,
  output logic        o_tx_align_en,
  output logic        o_phy_ready,
  output logic        o_oob_fail,
  output logic [2:0]  o_state,
  output logic [15:0] o_comreset_cnt,
  output logic [15:0] o_oob_fail_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CRWAIT   = 3'd1,
    ST_SCOMINIT = 3'd2,
    ST_WWAKE    = 3'd3,
    ST_SCOMWAKE = 3'd4,
    ST_SALIGN   = 3'd5,
    ST_READY    = 3'd6,
    ST_FAIL     = 3'd7
  } state_t;

  // Timer values at which each wait ends (counter == limit-1).
  localparam logic [19:0] L_CI_LAST = 20'(COMINIT_DELAY_CYC - 1);
  localparam logic [19:0] L_WK_LAST = 20'(WAKE_TIMEOUT_CYC - 1);
  localparam logic [19:0] L_AL_LAST = 20'(ALIGN_TIMEOUT_CYC - 1);
  localparam logic [19:0] L_CF_LAST = 20'(COMFINISH_TIMEOUT_CYC - 1);
  localparam int          RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] L_MAX_RETRY = RW'(MAX_RETRY);

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_cr_sync;
  logic [2:0]      r_cw_sync;
  logic [2:0]      r_cf_sync;
  logic [1:0]      r_al_sync;
  logic            w_cr_edge;
  logic            w_cw_edge;
  logic            w_cf_edge;
  logic            w_aligned;
  logic [19:0]     r_timer;
  logic            w_restart;
  logic            w_timer_clr;
  logic [RW-1:0]   r_retry;
  logic [RW-1:0]   w_retry_nx;
  logic [2:0]      r_algn_cnt;
  logic            r_tx_cominit;
  logic            r_tx_comwake;
  logic            r_tx_elecidle;
  logic            r_tx_align_en;
  logic            r_phy_ready;
  logic            r_oob_fail;

  // Two-flop synchronisers plus one delay flop for rising-edge detection.
  always_ff @(posedge cpll_refclk or negedge rstn) begin
    if (!rstn) begin
      r_cr_sync <= 3'b000;
      r_cw_sync <= 3'b000;
      r_cf_sync <= 3'b000;
      r_al_sync <= 2'b00;
    end else begin
      r_cr_sync <= {r_cr_sync[1:0], i_rx_comreset_det};
      r_cw_sync <= {r_cw_sync[1:0], i_rx_comwake_det};
      r_cf_sync <= {r_cf_sync[1:0], i_tx_comfinish};
      r_al_sync <= {r_al_sync[0], i_rx_aligned};
    end
  end

  assign w_cr_edge = r_cr_sync[1] & ~r_cr_sync[2];
  assign w_cw_edge = r_cw_sync[1] & ~r_cw_sync[2];
  assign w_cf_edge = r_cf_sync[1] & ~r_cf_sync[2];
  assign w_aligned = r_al_sync[1];

  // Next-state logic; a COMRESET edge outside CRWAIT overrides everything.
  always_comb begin
    w_next     = r_state;
    w_restart  = 1'b0;
    w_retry_nx = r_retry;
    if (w_cr_edge && (r_state != ST_CRWAIT)) begin
      w_next = ST_CRWAIT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_next = ST_IDLE;
        end
        ST_CRWAIT: begin
          if (w_cr_edge) begin
            w_restart = 1'b1;
          end else if (r_timer == L_CI_LAST) begin
            w_next     = ST_SCOMINIT;
            w_retry_nx = {RW{1'b0}};
          end else begin
            w_next = ST_CRWAIT;
          end
        end
        ST_SCOMINIT: begin
          if (w_cf_edge) begin
            w_next = ST_WWAKE;
          end else if (r_timer == L_CF_LAST) begin
            w_next = ST_FAIL;
          end else begin
            w_next = ST_SCOMINIT;
          end
        end
        ST_WWAKE: begin
          if (w_cw_edge) begin
            w_next = ST_SCOMWAKE;
          end else if (r_timer == L_WK_LAST) begin
            if (r_retry < L_MAX_RETRY) begin
              w_retry_nx = r_retry + {{(RW-1){1'b0}}, 1'b1};
              w_next     = ST_SCOMINIT;
            end else begin
              w_next = ST_FAIL;
            end
          end else begin
            w_next = ST_WWAKE;
          end
        end
        ST_SCOMWAKE: begin
          if (w_cf_edge) begin
            w_next = ST_SALIGN;
          end else if (r_timer == L_CF_LAST) begin
            w_next = ST_FAIL;
          end else begin
            w_next = ST_SCOMWAKE;
          end
        end
        ST_SALIGN: begin
          if (w_aligned && (r_algn_cnt == 3'd7)) begin
            w_next = ST_READY;
          end else if (r_timer == L_AL_LAST) begin
            w_next = ST_FAIL;
          end else begin
            w_next = ST_SALIGN;
          end
        end
        ST_READY: begin
          if (!w_aligned) begin
            w_next = ST_SALIGN;
          end else begin
            w_next = ST_READY;
          end
        end
        ST_FAIL: begin
          w_next = ST_IDLE;
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
    w_timer_clr = w_restart | (w_next != r_state);
  end

  // State register, shared timer, retry and ALIGN-run counters.
  always_ff @(posedge cpll_refclk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_timer    <= 20'd0;
      r_retry    <= {RW{1'b0}};
      r_algn_cnt <= 3'd0;
    end else begin
      r_state <= w_next;
      r_retry <= w_retry_nx;
      if (w_timer_clr) begin
        r_timer <= 20'd0;
      end else begin
        r_timer <= r_timer + 20'd1;
      end
      if ((r_state == ST_SALIGN) && (w_next == ST_SALIGN) && w_aligned) begin
        r_algn_cnt <= r_algn_cnt + 3'd1;
      end else begin
        r_algn_cnt <= 3'd0;
      end
    end
  end

  // Outputs decoded from the next state so they change together with r_state.
  always_ff @(posedge cpll_refclk or negedge rstn) begin
    if (!rstn) begin
      r_tx_cominit  <= 1'b0;
      r_tx_comwake  <= 1'b0;
      r_tx_elecidle <= 1'b1;
      r_tx_align_en <= 1'b0;
      r_phy_ready   <= 1'b0;
      r_oob_fail    <= 1'b0;
    end else begin
      r_tx_cominit  <= (w_next == ST_SCOMINIT);
      r_tx_comwake  <= (w_next == ST_SCOMWAKE);
      r_tx_elecidle <= !((w_next == ST_SALIGN) || (w_next == ST_READY));
      r_tx_align_en <= (w_next == ST_SALIGN) || (w_next == ST_READY);
      r_phy_ready   <= (w_next == ST_READY);
      r_oob_fail    <= (w_next == ST_FAIL);
    end
  end

  assign o_tx_cominit  = r_tx_cominit;
  assign o_tx_comwake  = r_tx_comwake;
  assign o_tx_elecidle = r_tx_elecidle;
  assign o_tx_align_en = r_tx_align_en;
  assign o_phy_ready   = r_phy_ready;
  assign o_oob_fail    = r_oob_fail;
  assign o_state       = r_state;

`ifdef SATA_DEV_OOB_STATS_EN
  logic [15:0] r_comreset_cnt;
  logic [15:0] r_oob_fail_cnt;

  // Saturating event counters, cleared only by rstn.
  always_ff @(posedge cpll_refclk or negedge rstn) begin
    if (!rstn) begin
      r_comreset_cnt <= 16'h0000;
      r_oob_fail_cnt <= 16'h0000;
    end else begin
      if (w_cr_edge && (r_comreset_cnt != 16'hFFFF)) begin
        r_comreset_cnt <= r_comreset_cnt + 16'h0001;
      end else begin
        r_comreset_cnt <= r_comreset_cnt;
      end
      if ((w_next == ST_FAIL) && (r_state != ST_FAIL) && (r_oob_fail_cnt != 16'hFFFF)) begin
        r_oob_fail_cnt <= r_oob_fail_cnt + 16'h0001;
      end else begin
        r_oob_fail_cnt <= r_oob_fail_cnt;
      end
    end
  end

  assign o_comreset_cnt = r_comreset_cnt;
  assign o_oob_fail_cnt = r_oob_fail_cnt;
`else
  assign o_comreset_cnt = 16'h0000;
  assign o_oob_fail_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sata_dev_oob_ctrl.sv
// Directed bench for sata_dev_oob_ctrl (wake timeout shortened to 100 cycles).
module tb_sata_dev_oob_ctrl;

  logic        rstn;
  logic        cpll_refclk;
  logic        i_rx_comreset_det;
  logic        i_rx_comwake_det;
  logic        i_tx_comfinish;
  logic        i_rx_aligned;
  logic        o_tx_cominit;
  logic        o_tx_comwake;
  logic        o_tx_elecidle;
  logic        o_tx_align_en;
  logic        o_phy_ready;
  logic        o_oob_fail;
  logic [2:0]  o_state;
  logic [15:0] o_comreset_cnt;
  logic [15:0] o_oob_fail_cnt;

  int n_err;
  int n_checks;
  int n_ci;
  int ci0;
  logic r_prev_ci;

`ifdef SATA_DEV_OOB_STATS_EN
  localparam int EXP_CR_CNT   = 9;
  localparam int EXP_FAIL_CNT = 1;
`else
  localparam int EXP_CR_CNT   = 0;
  localparam int EXP_FAIL_CNT = 0;
`endif

  sata_dev_oob_ctrl #(
    .COMINIT_DELAY_CYC     (60),
    .WAKE_TIMEOUT_CYC      (100),
    .ALIGN_TIMEOUT_CYC     (52800),
    .COMFINISH_TIMEOUT_CYC (4096),
    .MAX_RETRY             (3)
  ) dut (
    .rstn              (rstn),
    .cpll_refclk       (cpll_refclk),
    .i_rx_comreset_det (i_rx_comreset_det),
    .i_rx_comwake_det  (i_rx_comwake_det),
    .i_tx_comfinish    (i_tx_comfinish),
    .i_rx_aligned      (i_rx_aligned),
    .o_tx_cominit      (o_tx_cominit),
    .o_tx_comwake      (o_tx_comwake),
    .o_tx_elecidle     (o_tx_elecidle),
    .o_tx_align_en     (o_tx_align_en),
    .o_phy_ready       (o_phy_ready),
    .o_oob_fail        (o_oob_fail),
    .o_state           (o_state),
    .o_comreset_cnt    (o_comreset_cnt),
    .o_oob_fail_cnt    (o_oob_fail_cnt)
  );

  initial cpll_refclk = 1'b0;
  always #8 cpll_refclk = ~cpll_refclk;

  // Count rising edges of the COMINIT request.
  initial begin
    n_ci = 0;
    r_prev_ci = 1'b0;
  end
  always @(posedge cpll_refclk) begin
    if (o_tx_cominit && !r_prev_ci) n_ci <= n_ci + 1;
    r_prev_ci <= o_tx_cominit;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge cpll_refclk);
    #1;
  endtask

  // Two-cycle pulse on the selected async inputs.
  task automatic pulse(input logic cr, input logic cw, input logic cf);
    i_rx_comreset_det = cr;
    i_rx_comwake_det  = cw;
    i_tx_comfinish    = cf;
    tick(2);
    i_rx_comreset_det = 1'b0;
    i_rx_comwake_det  = 1'b0;
    i_tx_comfinish    = 1'b0;
  endtask

  task automatic wait_cominit();
    int k;
    k = 0;
    while ((o_tx_cominit !== 1'b1) && (k < 300)) begin
      tick(1);
      k++;
    end
    chk("wait_cominit_bound", 32'(k < 300), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    n_err = 0;
    n_checks = 0;
    rstn = 1'b0;
    i_rx_comreset_det = 1'b0;
    i_rx_comwake_det  = 1'b0;
    i_tx_comfinish    = 1'b0;
    i_rx_aligned      = 1'b0;
    tick(3);
    chk("rst_state",    32'(o_state), 32'd0);
    chk("rst_elecidle", 32'(o_tx_elecidle), 32'd1);
    chk("rst_cominit",  32'(o_tx_cominit), 32'd0);
    chk("rst_comwake",  32'(o_tx_comwake), 32'd0);
    chk("rst_align_en", 32'(o_tx_align_en), 32'd0);
    chk("rst_phy_ready",32'(o_phy_ready), 32'd0);
    chk("rst_oob_fail", 32'(o_oob_fail), 32'd0);
    chk("rst_cr_cnt",   32'(o_comreset_cnt), 32'd0);
    chk("rst_fail_cnt", 32'(o_oob_fail_cnt), 32'd0);
    rstn = 1'b1;
    tick(5);
    chk("idle_hold", 32'(o_state), 32'd0);

    // Happy path
    pulse(1'b1, 1'b0, 1'b0);
    tick(1);
    chk("cr_to_crwait", 32'(o_state), 32'd1);
    tick(59);
    chk("crwait_t62", 32'(o_state), 32'd1);
    chk("crwait_no_cominit", 32'(o_tx_cominit), 32'd0);
    tick(1);
    chk("scominit_t63", 32'(o_state), 32'd2);
    chk("cominit_hi", 32'(o_tx_cominit), 32'd1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("cf_lat2_still_scominit", 32'(o_state), 32'd2);
    tick(1);
    chk("wwake", 32'(o_state), 32'd3);
    chk("cominit_lo", 32'(o_tx_cominit), 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    tick(1);
    chk("scomwake", 32'(o_state), 32'd4);
    chk("comwake_hi", 32'(o_tx_comwake), 32'd1);
    pulse(1'b0, 1'b0, 1'b1);
    tick(1);
    chk("salign", 32'(o_state), 32'd5);
    chk("salign_comwake_lo", 32'(o_tx_comwake), 32'd0);
    chk("salign_elecidle", 32'(o_tx_elecidle), 32'd0);
    chk("salign_align_en", 32'(o_tx_align_en), 32'd1);
    i_rx_aligned = 1'b1;
    tick(9);
    chk("align_t9_not_ready", 32'(o_phy_ready), 32'd0);
    tick(1);
    chk("ready_t10", 32'(o_state), 32'd6);
    chk("phy_ready_hi", 32'(o_phy_ready), 32'd1);
    chk("ready_elecidle", 32'(o_tx_elecidle), 32'd0);

    // Align loss for 5 cycles
    i_rx_aligned = 1'b0;
    tick(2);
    chk("loss_t2_ready", 32'(o_state), 32'd6);
    tick(1);
    chk("loss_t3_salign", 32'(o_state), 32'd5);
    chk("loss_phy_ready", 32'(o_phy_ready), 32'd0);
    tick(2);
    i_rx_aligned = 1'b1;
    tick(9);
    chk("relock_t9", 32'(o_state), 32'd5);
    tick(1);
    chk("relock_t10", 32'(o_state), 32'd6);
    chk("relock_phy_ready", 32'(o_phy_ready), 32'd1);

    // Override: COMRESET from READY, then COMRESET coincident with comfinish in SCOMWAKE
    pulse(1'b1, 1'b0, 1'b0);
    tick(1);
    chk("ovr_ready_to_crwait", 32'(o_state), 32'd1);
    chk("ovr_phy_ready_lo", 32'(o_phy_ready), 32'd0);
    tick(60);
    chk("ovr_scominit", 32'(o_state), 32'd2);
    pulse(1'b0, 1'b0, 1'b1);
    tick(1);
    pulse(1'b0, 1'b1, 1'b0);
    tick(1);
    chk("ovr_scomwake", 32'(o_state), 32'd4);
    pulse(1'b1, 1'b0, 1'b1);
    chk("ovr_comwake_before", 32'(o_tx_comwake), 32'd1);
    tick(1);
    chk("ovr_crwait_wins", 32'(o_state), 32'd1);
    chk("ovr_comwake_lo", 32'(o_tx_comwake), 32'd0);

    // Burst: 6 COMRESET pulses 20 cycles apart
    ci0 = n_ci;
    for (int i = 0; i < 6; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      chk("burst_crwait", 32'(o_state), 32'd1);
      chk("burst_no_cominit", 32'(o_tx_cominit), 32'd0);
      if (i < 5) tick(18);
    end
    tick(60);
    chk("burst_t62", 32'(o_state), 32'd1);
    tick(1);
    chk("burst_t63", 32'(o_state), 32'd2);
    tick(1);
    chk("burst_one_cominit", 32'(n_ci - ci0), 32'd1);

    // Wake retry: answer every COMINIT, never send COMWAKE
    for (int r = 0; r < 4; r++) begin
      wait_cominit();
      pulse(1'b0, 1'b0, 1'b1);
      tick(1);
      chk("retry_wwake", 32'(o_state), 32'd3);
    end
    tick(99);
    chk("retry_last_wwake", 32'(o_state), 32'd3);
    tick(1);
    chk("retry_fail_state", 32'(o_state), 32'd7);
    chk("retry_oob_fail_hi", 32'(o_oob_fail), 32'd1);
    chk("retry_no_5th", 32'(o_tx_cominit), 32'd0);
    tick(1);
    chk("retry_idle", 32'(o_state), 32'd0);
    chk("retry_oob_fail_lo", 32'(o_oob_fail), 32'd0);
    chk("retry_cominit_total", 32'(n_ci - ci0), 32'd4);
    chk("stat_cr_cnt", 32'(o_comreset_cnt), 32'(EXP_CR_CNT));
    chk("stat_fail_cnt", 32'(o_oob_fail_cnt), 32'(EXP_FAIL_CNT));

    // Reset in SALIGN
    i_rx_aligned = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    tick(61);
    chk("mr_scominit", 32'(o_state), 32'd2);
    pulse(1'b0, 1'b0, 1'b1);
    tick(1);
    pulse(1'b0, 1'b1, 1'b0);
    tick(1);
    pulse(1'b0, 1'b0, 1'b1);
    tick(1);
    chk("mr_salign", 32'(o_state), 32'd5);
    tick(2);
    #3;
    rstn = 1'b0;
    #1;
    chk("mr_state",     32'(o_state), 32'd0);
    chk("mr_elecidle",  32'(o_tx_elecidle), 32'd1);
    chk("mr_align_en",  32'(o_tx_align_en), 32'd0);
    chk("mr_cominit",   32'(o_tx_cominit), 32'd0);
    chk("mr_comwake",   32'(o_tx_comwake), 32'd0);
    chk("mr_phy_ready", 32'(o_phy_ready), 32'd0);
    chk("mr_oob_fail",  32'(o_oob_fail), 32'd0);
    chk("mr_cr_cnt",    32'(o_comreset_cnt), 32'd0);
    chk("mr_fail_cnt",  32'(o_oob_fail_cnt), 32'd0);
    tick(2);
    rstn = 1'b1;
    tick(3);
    chk("mr_idle_after", 32'(o_state), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
